// File: rtl/smmha_tile_sched_if.sv
// smmha_tile_sched_if: tile-request channel between the tile scheduler
// (master) and the data streamer (slave). Signal names keep the scheduler's
// point of view, so the _o signals are driven by the master.
interface smmha_tile_sched_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              req_valid_o;
  logic              req_ready_i;
  logic [ADDR_W-1:0] req_src_addr_o;
  logic [ADDR_W-1:0] req_dst_addr_o;
  logic [LEN_W-1:0]  req_len_o;

  modport master (
    output req_valid_o, req_src_addr_o, req_dst_addr_o, req_len_o,
    input  req_ready_i
  );

  modport slave (
    input  req_valid_o, req_src_addr_o, req_dst_addr_o, req_len_o,
    output req_ready_i
  );
endinterface

// File: rtl/smmha_tile_sched.sv
// smmha_tile_sched: splits a job of length_i elements into tiles of
// tile_len_i elements. For each tile it issues one streamer request
// (src/dst/len), pulses the engine start, waits for the engine done, then
// advances both addresses. done_o pulses once when the job is finished.
// Optional build macro SMMHA_TILE_SCHED_PERF_EN adds the cycles_o busy-cycle
// counter; without it there is no port and no counter.
module smmha_tile_sched #(
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int ELEM_BYTES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] in_base_addr_i,
  input  logic [ADDR_W-1:0] out_base_addr_i,
  input  logic [31:0]       length_i,
  input  logic [LEN_W-1:0]  tile_len_i,
  smmha_tile_sched_if.master req_if,
  output logic              eng_start_o,
  input  logic              eng_done_i,
  output logic              busy_o,
  output logic              done_o,
`ifdef SMMHA_TILE_SCHED_PERF_EN
  output logic [31:0]       cycles_o,
`endif
  output logic [LEN_W-1:0]  tile_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [31:0]       rem_q, rem_d;
  logic [LEN_W-1:0]  tile_q, tile_d;
  logic [LEN_W-1:0]  idx_q, idx_d;

  logic [LEN_W-1:0]  cur_len;
  logic [ADDR_W-1:0] step;
  logic [31:0]       rem_after;

  // Current tile length is the smaller of tile size and what is left; the
  // address step and remaining count follow from it.
  always_comb begin
    cur_len   = (rem_q < 32'(tile_q)) ? rem_q[LEN_W-1:0] : tile_q;
    step      = ADDR_W'(cur_len) * ADDR_W'(ELEM_BYTES);
    rem_after = rem_q - 32'(cur_len);
  end

  // Next-state and datapath update for the job sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    tile_d  = tile_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d   = in_base_addr_i;
          dst_d   = out_base_addr_i;
          rem_d   = length_i;
          // A zero tile size would never make progress; use one element.
          tile_d  = (tile_len_i == '0) ? LEN_W'(1) : tile_len_i;
          idx_d   = '0;
          state_d = (length_i == 32'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (req_if.req_ready_i) state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done_i) begin
          rem_d   = rem_after;
          src_d   = src_q + step;
          dst_d   = dst_q + step;
          idx_d   = idx_q + LEN_W'(1);
          state_d = (rem_after == 32'd0) ? S_DONE : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset and soft clear both abort the job.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      tile_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      tile_q  <= tile_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SMMHA_TILE_SCHED_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // Busy-cycle counter: restarts on an accepted start, saturates at all-ones.
  always_comb begin
    cycles_d = cycles_q;
    if (state_q == S_IDLE && start_i)             cycles_d = '0;
    else if (state_q != S_IDLE && cycles_q != '1) cycles_d = cycles_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) cycles_q <= '0;
    else                  cycles_q <= cycles_d;
  end

  assign cycles_o = cycles_q;
`endif

  // Moore outputs decoded from the state; all fields are zero after reset.
  always_comb begin
    req_if.req_valid_o    = (state_q == S_REQ);
    req_if.req_src_addr_o = src_q;
    req_if.req_dst_addr_o = dst_q;
    req_if.req_len_o      = cur_len;
    eng_start_o           = (state_q == S_START);
    busy_o                = (state_q != S_IDLE);
    done_o                = (state_q == S_DONE);
    tile_idx_o            = idx_q;
  end

endmodule

// File: tb/tb_smmha_tile_sched.sv
// tb_smmha_tile_sched: scoreboard bench. Each job start pushes the expected
// tile requests and tile count, derived in closed form from the job
// parameters; a negedge monitor pops and compares on every handshake and
// done pulse. Engine and streamer-ready are modelled with random delays.
module tb_smmha_tile_sched;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int EB     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, clr = 1'b0, start = 1'b0, start_x = 1'b0;
  logic        start_w;
  logic [31:0] in_a = '0, out_a = '0, len = '0;
  logic [15:0] tile = '0;
  logic        eng_start, eng_done_auto = 1'b0, eng_done_frc = 1'b0, eng_done;
  logic        busy, done;
  logic [15:0] tidx;
`ifdef SMMHA_TILE_SCHED_PERF_EN
  logic [31:0] cycles;
`endif

  assign start_w  = start | start_x;
  assign eng_done = eng_done_auto | eng_done_frc;

  smmha_tile_sched_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) rif ();

  smmha_tile_sched #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ELEM_BYTES(EB)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start_w),
    .in_base_addr_i(in_a), .out_base_addr_i(out_a),
    .length_i(len), .tile_len_i(tile),
    .req_if(rif.master),
    .eng_start_o(eng_start), .eng_done_i(eng_done),
    .busy_o(busy), .done_o(done),
`ifdef SMMHA_TILE_SCHED_PERF_EN
    .cycles_o(cycles),
`endif
    .tile_idx_o(tidx)
  );

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } req_t;

  req_t        exp_q[$];
  logic [15:0] exp_done_q[$];
  int checks = 0, fails = 0;
  int jobs_done = 0, jd_base = 0;
  int rdy_mode = 2;   // 0 random, 1 held low, 2 held high
  int eng_dly  = 3;   // 0 means random 1..4

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: tile k covers elements [k*t, min((k+1)*t, len)), so its
  // addresses are base + k*t*EB and all tiles but the last are full.
  task automatic push_job(logic [31:0] ia, logic [31:0] oa, logic [31:0] l, logic [15:0] tl);
    longint unsigned t, n, l64;
    req_t r;
    t   = (tl == 0) ? 1 : longint'(tl);
    l64 = longint'(l);
    n   = (l64 + t - 1) / t;
    for (longint unsigned k = 0; k < n; k++) begin
      r.src = ia + 32'(k * t * EB);
      r.dst = oa + 32'(k * t * EB);
      r.len = 16'((l64 - k * t < t) ? (l64 - k * t) : t);
      exp_q.push_back(r);
    end
    exp_done_q.push_back(16'(n));
  endtask

  // Streamer ready driver.
  initial begin
    rif.req_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      rif.req_ready_i = (rdy_mode == 2) ? 1'b1 :
                        (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Engine model: done pulse some cycles after each start pulse.
  initial begin
    int d;
    forever begin
      @(posedge clk); #1;
      if (eng_start === 1'b1) begin
        d = (eng_dly == 0) ? int'($urandom_range(1, 4)) : eng_dly;
        repeat (d) @(posedge clk);
        #1 eng_done_auto = 1'b1;
        @(posedge clk);
        #1 eng_done_auto = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  int   pend = 0, bc = 0, bc_snap = 0;
  logic prev_stall = 0, prev_es = 0, post_done = 0, cyc_chk = 0;
  req_t prev_req, cur, e;
  always @(negedge clk) begin
    cur = '{rif.req_src_addr_o, rif.req_dst_addr_o, rif.req_len_o};
    if (rst || clr) begin
      exp_q.delete();
      exp_done_q.delete();
      pend = 0; prev_stall = 0; prev_es = 0; post_done = 0; cyc_chk = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(rif.req_valid_o), 64'd1);
        chk("hold_src", 64'(cur.src), 64'(prev_req.src));
        chk("hold_dst", 64'(cur.dst), 64'(prev_req.dst));
        chk("hold_len", 64'(cur.len), 64'(prev_req.len));
      end
      if (rif.req_valid_o && rif.req_ready_i) begin
        chk("req_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("req_src", 64'(cur.src), 64'(e.src));
          chk("req_dst", 64'(cur.dst), 64'(e.dst));
          chk("req_len", 64'(cur.len), 64'(e.len));
        end
        pend++;
      end
      prev_stall = rif.req_valid_o && !rif.req_ready_i;
      prev_req   = cur;
      if (eng_start) begin
        chk("eng_start_after_hs", 64'(pend > 0), 64'd1);
        chk("eng_start_pulse", 64'(prev_es), 64'd0);
        if (pend > 0) pend--;
      end
      prev_es = eng_start;
      if (start_w && !busy) bc = 0;
      else if (busy)        bc++;
`ifdef SMMHA_TILE_SCHED_PERF_EN
      if (cyc_chk) begin
        chk("cycles", 64'(cycles), 64'(bc_snap));
        cyc_chk = 0;
      end
`endif
      if (done) begin
        chk("done_expected", 64'(exp_done_q.size() > 0), 64'd1);
        if (exp_done_q.size() > 0) chk("done_tiles", 64'(tidx), 64'(exp_done_q.pop_front()));
        jobs_done++;
        post_done = 1; cyc_chk = 1; bc_snap = bc;
      end else if (post_done) begin
        chk("idle_after_done", 64'(busy), 64'd0);
        post_done = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    chk("idle_before_start", 64'(busy), 64'd0);
  endtask

  task automatic start_job(logic [31:0] ia, logic [31:0] oa, logic [31:0] l, logic [15:0] tl);
    wait_idle();
    push_job(ia, oa, l, tl);
    jd_base = jobs_done;
    @(posedge clk); #1;
    start = 1'b1; in_a = ia; out_a = oa; len = l; tile = tl;
    @(posedge clk); #1;
    // Scramble config so a late sample would show up as a wrong address.
    start = 1'b0; in_a = $urandom; out_a = $urandom; len = $urandom; tile = 16'($urandom);
  endtask

  task automatic wait_job();
    for (int i = 0; i < 3000 && jobs_done == jd_base; i++) @(negedge clk);
    chk("job_done_seen", 64'(jobs_done - jd_base), 64'd1);
  endtask

  task automatic run_job(logic [31:0] ia, logic [31:0] oa, logic [31:0] l, logic [15:0] tl);
    start_job(ia, oa, l, tl);
    wait_job();
  endtask

  task automatic chk_zero(string tag);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(rif.req_valid_o), 64'd0);
    chk({tag, "_src"}, 64'(rif.req_src_addr_o), 64'd0);
    chk({tag, "_dst"}, 64'(rif.req_dst_addr_o), 64'd0);
    chk({tag, "_len"}, 64'(rif.req_len_o), 64'd0);
    chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_tidx"}, 64'(tidx), 64'd0);
`ifdef SMMHA_TILE_SCHED_PERF_EN
    chk({tag, "_cycles"}, 64'(cycles), 64'd0);
`endif
  endtask

  task automatic wait_nth_eng_start(int n);
    int seen = 0;
    for (int i = 0; i < 500 && seen < n; i++) begin
      @(negedge clk);
      if (eng_start) seen++;
    end
    chk("eng_start_seen", 64'(seen), 64'(n));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("reset");

    // Directed 10 elements in tiles of 4, engine done 3 cycles after start.
    rdy_mode = 2; eng_dly = 3;
    run_job(32'h1000, 32'h2000, 32'd10, 16'd4);

    // Zero length: done in the cycle after acceptance, no request.
    wait_idle();
    push_job(32'h0, 32'h0, 32'd0, 16'd4);
    jd_base = jobs_done;
    @(posedge clk); #1 start = 1'b1; len = 32'd0; tile = 16'd4;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_valid", 64'(rif.req_valid_o), 64'd0);
    wait_job();

    // Streamer stalls the first request for 5 cycles.
    rdy_mode = 1;
    fork
      run_job(32'h3000, 32'h7000, 32'd10, 16'd4);
      begin repeat (7) @(posedge clk); rdy_mode = 2; end
    join

    // Source address wraps past the top of the address space.
    run_job(32'hFFFF_FFF8, 32'h0000_0100, 32'd8, 16'd4);
    // Zero tile size acts as one.
    run_job(32'h0000_0040, 32'h0000_0080, 32'd3, 16'd0);

    // Spurious start during WAIT, then spurious engine done in IDLE.
    fork
      run_job(32'h4000, 32'h5000, 32'd8, 16'd4);
      begin
        wait_nth_eng_start(1);
        @(posedge clk); #1 start_x = 1'b1;
        @(posedge clk); #1 start_x = 1'b0;
      end
    join
    repeat (8) @(posedge clk);
    #1 eng_done_frc = 1'b1;
    @(posedge clk); #1 eng_done_frc = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", 64'(busy), 64'd0);
    chk("idle_done_tidx", 64'(tidx), 64'd2);

    // Reset during WAIT of tile 1: aborted, no done afterwards.
    start_job(32'h1000, 32'h2000, 32'd10, 16'd4);
    wait_nth_eng_start(2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_zero("abort_rst");
    @(posedge clk); #1 eng_done_frc = 1'b1;
    @(posedge clk); #1 eng_done_frc = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_rst_busy", 64'(busy), 64'd0);
    chk("abort_rst_no_done", 64'(jobs_done), 64'(jd_base));

    // Soft clear while a request is stalled: request dropped.
    rdy_mode = 1;
    start_job(32'h8000, 32'h9000, 32'd12, 16'd5);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0; rdy_mode = 2;
    chk_zero("abort_clr");
    repeat (10) @(negedge clk);
    chk("abort_clr_no_done", 64'(jobs_done), 64'(jd_base));

    // Randomized jobs with random stalls and engine latency.
    rdy_mode = 0; eng_dly = 0;
    for (int j = 0; j < 25; j++)
      run_job($urandom, $urandom, 32'($urandom_range(0, 40)), 16'($urandom_range(0, 9)));

    repeat (5) @(negedge clk);
    chk("exp_req_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_done_drained", 64'(exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
